apb_reg_slave: RTL and testbench

APB3/APB4 completer that terminates the APB side of the synchronous AHB-to-APB bridge. It provides a bank of DATAWIDTH-bit registers and inserts a configurable number of wait states via PREADY. It flags PSLVERR for illegal accesses. It runs on the bridge clock and qualifies every APB sample with PCLKEN, so it sits directly on the bridge's APB outputs.

---
 rtl/apb_reg_slave.sv | 150 +++++++++++++++
 tb/tb_apb_reg_slave.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_slave.sv
// APB3/APB4 register-bank completer for the AHB-to-APB bridge.
// Runs on the bridge clock. Every APB sample is qualified by PCLKEN.
// Wait states are inserted through PREADY, and illegal accesses return PSLVERR.
module apb_reg_slave #(
    parameter int unsigned ADDRWIDTH   = 16,
    parameter int unsigned DATAWIDTH   = 32,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [DATAWIDTH-1:0] ID_VALUE = 32'hA5B0_0001
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          PCLKEN,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic [ADDRWIDTH-1:0]          PADDR,
    input  logic                          PWRITE,
    input  logic [DATAWIDTH-1:0]          PWDATA,
    input  logic [3:0]                    PSTRB,
    input  logic [2:0]                    PPROT,
    output logic [DATAWIDTH-1:0]          PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    output logic [NUM_REGS*DATAWIDTH-1:0] REG_Q,
    output logic [NUM_REGS-1:0]           WR_PULSE
);

    localparam int unsigned IDXW = ADDRWIDTH - 2;
    localparam int unsigned CNTW = 4;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                 state_q;
    logic [CNTW-1:0]        cnt_q;
    logic [IDXW-1:0]        idx_q;
    logic                   write_q;
    logic                   priv_q;
    logic [3:0]             strb_q;
    logic [DATAWIDTH-1:0]   wdata_q;
    logic [DATAWIDTH-1:0]   regs_q [NUM_REGS-1:1];

    logic [IDXW-1:0]        setup_idx_c;
    logic                   setup_err_c;
    logic                   cap_err_c;
    logic [DATAWIDTH-1:0]   setup_rd_c;
    logic [DATAWIDTH-1:0]   cap_rd_c;
    logic                   commit_c;
    logic [NUM_REGS-1:0]    wr_mask_c;
    logic [DATAWIDTH-1:0]   byte_mask_c;
    logic                   unused_c;

    // Byte-lane ignored address bits and non-privilege PPROT bits
    assign unused_c = ^{PADDR[1:0], PPROT[2:1]};

    // Flat register view; slot 0 is the constant ID
    assign REG_Q[DATAWIDTH-1:0] = ID_VALUE;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_regq
        assign REG_Q[g*DATAWIDTH +: DATAWIDTH] = regs_q[g];
    end

    // Decode of the setup-phase address and the captured transfer
    always_comb begin
        setup_idx_c = PADDR[ADDRWIDTH-1:2];
        setup_err_c = (32'(setup_idx_c) >= NUM_REGS) ||
                      (PWRITE && ((setup_idx_c == '0) || !PPROT[0]));
        cap_err_c   = (32'(idx_q) >= NUM_REGS) ||
                      (write_q && ((idx_q == '0) || !priv_q));
        setup_rd_c  = DATAWIDTH'(REG_Q >> {setup_idx_c, 5'd0});
        cap_rd_c    = DATAWIDTH'(REG_Q >> {idx_q, 5'd0});
        commit_c    = PCLKEN && (state_q == ACCESS) && PSEL && PENABLE && PREADY &&
                      write_q && !cap_err_c;
        wr_mask_c   = commit_c ? (NUM_REGS'(1) << idx_q) : '0;
        byte_mask_c = {{8{strb_q[3]}}, {8{strb_q[2]}}, {8{strb_q[1]}}, {8{strb_q[0]}}};
    end

    // Register bank: strobed byte merge on a legal completing write
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                regs_q[g] <= '0;
            end else if (wr_mask_c[g]) begin
                regs_q[g] <= (regs_q[g] & ~byte_mask_c) | (wdata_q & byte_mask_c);
            end
        end
    end

    // APB transfer FSM with registered response outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            priv_q   <= 1'b0;
            strb_q   <= '0;
            wdata_q  <= '0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            PRDATA   <= '0;
            WR_PULSE <= '0;
        end else begin
            WR_PULSE <= wr_mask_c;
            if (PCLKEN) begin
                case (state_q)
                    IDLE: begin
                        if (PSEL && !PENABLE) begin
                            state_q <= ACCESS;
                            cnt_q   <= CNTW'(WAIT_CYCLES);
                            idx_q   <= setup_idx_c;
                            write_q <= PWRITE;
                            priv_q  <= PPROT[0];
                            strb_q  <= PSTRB;
                            wdata_q <= PWDATA;
                            if (WAIT_CYCLES == 0) begin
                                PREADY  <= 1'b1;
                                PSLVERR <= setup_err_c;
                                PRDATA  <= (!PWRITE && !setup_err_c) ? setup_rd_c : '0;
                            end
                        end
                    end
                    ACCESS: begin
                        if (!PSEL) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            PREADY  <= 1'b0;
                            PSLVERR <= 1'b0;
                            PRDATA  <= '0;
                        end else if (PREADY) begin
                            if (PENABLE) begin
                                state_q <= IDLE;
                                PREADY  <= 1'b0;
                                PSLVERR <= 1'b0;
                                PRDATA  <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNTW'(1);
                            if (cnt_q == CNTW'(1)) begin
                                PREADY  <= 1'b1;
                                PSLVERR <= cap_err_c;
                                PRDATA  <= (!write_q && !cap_err_c) ? cap_rd_c : '0;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: three instances with different wait-state settings
// share one APB bus and are selected one at a time. Each instance has its own
// register-array reference model.
module tb_apb_reg_slave;

    localparam int unsigned NR   = 8;
    localparam int unsigned DW   = 32;
    localparam int unsigned NDUT = 3;
    localparam int unsigned WAITS [NDUT] = '{0, 2, 3};
    localparam logic [31:0] ID   = 32'hA5B0_0001;

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic            PCLKEN;
    logic            PENABLE;
    logic            PWRITE;
    logic [15:0]     PADDR;
    logic [31:0]     PWDATA;
    logic [3:0]      PSTRB;
    logic [2:0]      PPROT;
    logic [NDUT-1:0] psel;
    logic [NDUT-1:0] pready;
    logic [NDUT-1:0] pslverr;
    logic [31:0]     prdata   [NDUT];
    logic [NR*DW-1:0] reg_q   [NDUT];
    logic [NR-1:0]   wr_pulse [NDUT];

    logic [31:0]     mdl [NDUT][NR];
    bit              toggle;
    int              passes;
    int              total;

    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        apb_reg_slave #(.WAIT_CYCLES(WAITS[g])) u_dut (
            .HCLK     (HCLK),
            .HRESETn  (HRESETn),
            .PCLKEN   (PCLKEN),
            .PSEL     (psel[g]),
            .PENABLE  (PENABLE),
            .PADDR    (PADDR),
            .PWRITE   (PWRITE),
            .PWDATA   (PWDATA),
            .PSTRB    (PSTRB),
            .PPROT    (PPROT),
            .PRDATA   (prdata[g]),
            .PREADY   (pready[g]),
            .PSLVERR  (pslverr[g]),
            .REG_Q    (reg_q[g]),
            .WR_PULSE (wr_pulse[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One HCLK edge; outputs are sampled 1 time unit later
    task automatic step();
        @(posedge HCLK);
        #1;
        PCLKEN = toggle ? ~PCLKEN : 1'b1;
    endtask

    // Advance through the next PCLKEN-qualified edge. Outputs must hold on
    // edges where PCLKEN is low.
    task automatic pclk_step(input int k);
        bit          en;
        logic        r0;
        logic        e0;
        logic [31:0] d0;
        do begin
            en = PCLKEN;
            r0 = pready[k];
            e0 = pslverr[k];
            d0 = prdata[k];
            step();
            if (!en) begin
                chk("hold_pready", 32'(pready[k]), 32'(r0));
                chk("hold_pslverr", 32'(pslverr[k]), 32'(e0));
                chk("hold_prdata", prdata[k], d0);
            end
        end while (!en);
    endtask

    task automatic chk_regs(input int k, input string tag);
        for (int i = 0; i < NR; i++)
            chk(tag, reg_q[k][i*DW +: DW], (i == 0) ? ID : mdl[k][i]);
    endtask

    task automatic xfer(input int k, input logic [15:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [2:0] prot);
        int          idx;
        int          waits;
        bit          err;
        logic [31:0] exp_rd;
        logic [7:0]  exp_p;
        idx    = int'(addr[15:2]);
        err    = (idx >= NR) || (wr && ((idx == 0) || !prot[0]));
        exp_rd = (wr || err) ? 32'h0 : ((idx == 0) ? ID : mdl[k][idx]);
        exp_p  = '0;
        if (wr && !err) exp_p[idx] = 1'b1;

        psel    = '0;
        psel[k] = 1'b1;
        PENABLE = 1'b0;
        PADDR   = addr;
        PWRITE  = wr;
        PWDATA  = wdata;
        PSTRB   = strb;
        PPROT   = prot;
        pclk_step(k);
        PENABLE = 1'b1;

        waits = 0;
        while (!pready[k] && waits < 40) begin
            chk("wait_pslverr", 32'(pslverr[k]), 32'h0);
            chk("wait_prdata", prdata[k], 32'h0);
            pclk_step(k);
            waits++;
        end
        chk("wait_count", 32'(waits), 32'(WAITS[k]));
        chk("pready", 32'(pready[k]), 32'h1);
        chk("pslverr", 32'(pslverr[k]), 32'(err));
        chk("prdata", prdata[k], exp_rd);

        pclk_step(k);
        if (wr && !err)
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[k][idx][8*b +: 8] = wdata[8*b +: 8];
        chk("wr_pulse", 32'(wr_pulse[k]), 32'(exp_p));
        chk("pready_done", 32'(pready[k]), 32'h0);
        chk("pslverr_done", 32'(pslverr[k]), 32'h0);
        chk("prdata_done", prdata[k], 32'h0);
        psel    = '0;
        PENABLE = 1'b0;
        chk_regs(k, "reg_q");
        step();
        chk("wr_pulse_fall", 32'(wr_pulse[k]), 32'h0);
    endtask

    initial begin
        logic [15:0] a;
        logic [13:0] ridx;
        passes  = 0;
        total   = 0;
        toggle  = 1'b0;
        HRESETn = 1'b0;
        PCLKEN  = 1'b1;
        psel    = '0;
        PENABLE = 1'b0;
        PADDR   = '0;
        PWRITE  = 1'b0;
        PWDATA  = '0;
        PSTRB   = '0;
        PPROT   = '0;
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < NR; i++) mdl[k][i] = '0;

        // Reset state
        repeat (3) step();
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_pready", 32'(pready[k]), 32'h0);
            chk("rst_pslverr", 32'(pslverr[k]), 32'h0);
            chk("rst_prdata", prdata[k], 32'h0);
            chk("rst_wr_pulse", 32'(wr_pulse[k]), 32'h0);
            chk_regs(k, "rst_reg_q");
        end
        HRESETn = 1'b1;
        step();

        // ID read with zero wait states
        xfer(0, 16'h0000, 1'b0, 32'h0, 4'hF, 3'b001);

        // Full write, strobed write, readback
        xfer(0, 16'h0004, 1'b1, 32'h1234_5678, 4'b1111, 3'b001);
        xfer(0, 16'h0004, 1'b1, 32'hFFFF_FFFF, 4'b0101, 3'b001);
        xfer(0, 16'h0004, 1'b0, 32'h0, 4'b0000, 3'b001);
        chk("slot1_value", reg_q[0][63:32], 32'h12FF_56FF);

        // PENABLE without a setup phase is ignored
        psel[0] = 1'b1;
        PENABLE = 1'b1;
        pclk_step(0);
        pclk_step(0);
        chk("no_setup_pready", 32'(pready[0]), 32'h0);
        psel    = '0;
        PENABLE = 1'b0;
        step();

        // Three wait states with PCLKEN toggling
        toggle = 1'b1;
        xfer(2, 16'h0010, 1'b1, 32'hAABB_CCDD, 4'hF, 3'b001);
        xfer(2, 16'h0010, 1'b0, 32'h0, 4'hF, 3'b000);
        toggle = 1'b0;
        PCLKEN = 1'b1;

        // Error responses
        xfer(0, 16'h0000, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b001);
        xfer(0, 16'h0020, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b001);
        xfer(0, 16'h0008, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b000);
        xfer(0, 16'h0020, 1'b0, 32'h0, 4'hF, 3'b001);

        // Abort during wait states
        psel[1] = 1'b1;
        PENABLE = 1'b0;
        PADDR   = 16'h000C;
        PWRITE  = 1'b1;
        PWDATA  = 32'h5555_AAAA;
        PSTRB   = 4'hF;
        PPROT   = 3'b001;
        pclk_step(1);
        PENABLE = 1'b1;
        pclk_step(1);
        chk("abort_pready_low", 32'(pready[1]), 32'h0);
        psel    = '0;
        PENABLE = 1'b0;
        pclk_step(1);
        chk("abort_pready", 32'(pready[1]), 32'h0);
        chk("abort_wr_pulse", 32'(wr_pulse[1]), 32'h0);
        chk_regs(1, "abort_reg_q");
        xfer(1, 16'h000C, 1'b1, 32'h0F0F_0F0F, 4'hF, 3'b011);

        // Reset in the middle of a wait-state write
        xfer(2, 16'h0014, 1'b1, 32'h0BAD_F00D, 4'hF, 3'b001);
        psel[2] = 1'b1;
        PENABLE = 1'b0;
        PADDR   = 16'h0018;
        PWRITE  = 1'b1;
        PWDATA  = 32'hCAFE_0001;
        PSTRB   = 4'hF;
        PPROT   = 3'b001;
        pclk_step(2);
        PENABLE = 1'b1;
        pclk_step(2);
        #1;
        HRESETn = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("midrst_pready", 32'(pready[k]), 32'h0);
            chk("midrst_pslverr", 32'(pslverr[k]), 32'h0);
            chk("midrst_prdata", prdata[k], 32'h0);
            chk("midrst_wr_pulse", 32'(wr_pulse[k]), 32'h0);
            for (int i = 0; i < NR; i++) mdl[k][i] = '0;
            chk_regs(k, "midrst_reg_q");
        end
        psel    = '0;
        PENABLE = 1'b0;
        step();
        HRESETn = 1'b1;
        step();
        xfer(2, 16'h0018, 1'b1, 32'hCAFE_0002, 4'hF, 3'b001);
        xfer(2, 16'h0018, 1'b0, 32'h0, 4'hF, 3'b001);

        // Randomized transfers against the reference model
        for (int n = 0; n < 80; n++) begin
            toggle = 1'($urandom_range(0, 1));
            ridx   = 14'($urandom_range(0, 9));
            a      = {ridx, 2'($urandom)};
            if ($urandom_range(0, 7) == 0) a = 16'($urandom);
            xfer(int'($urandom_range(0, NDUT - 1)), a, 1'($urandom),
                 $urandom, 4'($urandom),
                 {2'($urandom), 1'($urandom_range(0, 9) < 7)});
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
